// File: rtl/count_stream_checker.sv
// Receive-side checker for the 1-bit counter/mux stream.
// Finds the sender's count phase, then checks each bit.
//
// Ports:
//   clk        rising-edge clock
//   res        synchronous active-high reset
//   din_valid  din/sel hold a sample this cycle
//   din        received stream bit
//   sel        mode of this sample (0=AND, 1=XOR)
//   locked     phase recovered, checking active
//   phase      count expected for next sample (0 if unlocked)
//   err_pulse  1-cycle pulse: last locked sample mismatched
//   err_count  saturating mismatch count since reset
//   sync_loss  1-cycle pulse: lock dropped
module count_stream_checker #(
    parameter int LOCK_ERR_MAX = 3,
    parameter int ERR_CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 din_valid,
    input  logic                 din,
    input  logic                 sel,
    output logic                 locked,
    output logic [2:0]           phase,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 sync_loss
);

    localparam int MR_W = $clog2(LOCK_ERR_MAX + 1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           cand_q, cand_d;
    logic [2:0]           phase_q, phase_d;
    logic [MR_W-1:0]      miss_run_q, miss_run_d;
    logic                 locked_q, locked_d;
    logic                 err_pulse_q, err_pulse_d;
    logic                 sync_loss_q, sync_loss_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    logic [7:0]      surv;
    logic [3:0]      n_surv;
    logic [2:0]      hit_idx;
    logic            chk_miss;
    logic [MR_W-1:0] miss_inc;
    logic            drop;

    function automatic logic exp_bit(input logic [2:0] k,
                                     input logic       s);
        return s ? (k[0] ^ k[2]) : (k[0] & k[2]);
    endfunction

    // Hypothesis filter and lock-side compare, shared by
    // the next-state and output processes.
    always_comb begin
        surv    = '0;
        n_surv  = '0;
        hit_idx = '0;
        for (int k = 0; k < 8; k++) begin
            surv[k] = cand_q[k] & (exp_bit(3'(k), sel) == din);
            if (surv[k]) begin
                n_surv  = n_surv + 4'd1;
                hit_idx = 3'(k);
            end
        end
        chk_miss = (exp_bit(phase_q, sel) != din);
        miss_inc = miss_run_q + 1'b1;
        drop     = (state_q == LOCKED) && din_valid && chk_miss
                   && (miss_inc == MR_W'(LOCK_ERR_MAX));
    end

    // State register (all flops).
    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= HUNT;
            cand_q      <= 8'hFF;
            phase_q     <= '0;
            miss_run_q  <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            sync_loss_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            phase_q     <= phase_d;
            miss_run_q  <= miss_run_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            sync_loss_q <= sync_loss_d;
            err_count_q <= err_count_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (n_surv == 4'd1) begin
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (drop) begin
                        state_d = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Output / datapath logic.
    always_comb begin
        cand_d      = cand_q;
        phase_d     = phase_q;
        miss_run_d  = miss_run_q;
        err_count_d = err_count_q;
        err_pulse_d = 1'b0;
        sync_loss_d = 1'b0;
        locked_d    = (state_d == LOCKED);
        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (n_surv == 4'd1) begin
                        cand_d     = 8'hFF;
                        phase_d    = hit_idx + 3'd1;
                        miss_run_d = '0;
                    end else if (n_surv == 4'd0) begin
                        cand_d = 8'hFF;
                    end else begin
                        // Survivor at k predicts k+1 next.
                        cand_d = {surv[6:0], surv[7]};
                    end
                end
                LOCKED: begin
                    phase_d = phase_q + 3'd1;
                    if (!chk_miss) begin
                        miss_run_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        miss_run_d  = miss_inc;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                        if (drop) begin
                            cand_d      = 8'hFF;
                            phase_d     = '0;
                            miss_run_d  = '0;
                            sync_loss_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign locked    = locked_q;
    assign phase     = phase_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign sync_loss = sync_loss_q;

endmodule
